// File: rtl/vec_sweep_ctrl.sv
// Exhaustive input-sweep sequencer: applies 0..2^N_W-1 to a DUT, captures each response, streams {vec,resp} beats.
// Optional MISR signature over captured beats when VSC_MISR_EN is defined.
//   state   | meaning
//   IDLE    | waiting for start
//   APPLY   | drive current vector, load settle timer
//   SETTLE  | settle timer counting down
//   CAPTURE | sample DUT response into beat registers
//   EMIT    | beat offered to sink until accepted
//   DONE    | one-cycle completion pulse
module vec_sweep_ctrl #(
    parameter int N_W    = 3,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 1,
    parameter int SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h8016
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [N_W-1:0]   dut_n,
    input  logic [OUT_W-1:0] dut_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N_W-1:0]   res_vec,
    output logic [OUT_W-1:0] res_out,
    output logic [SIG_W-1:0] signature
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // SETTLE state lasts SETTLE cycles, so the timer terminates at zero after loading SETTLE-1
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_APPLY, S_SETTLE, S_CAPTURE, S_EMIT, S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [N_W-1:0]   vec_q, vec_d;
    logic [N_W-1:0]   dut_n_q, dut_n_d;
    logic [N_W-1:0]   res_vec_q, res_vec_d;
    logic [OUT_W-1:0] res_out_q, res_out_d;
    logic             res_valid_q, res_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic run_abort;
    logic go;

    assign run_abort = abort && (state_q != S_IDLE);
    assign go        = (state_q == S_IDLE) && start && !abort;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (run_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (go) state_d = S_APPLY;
                S_APPLY:   state_d = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
                S_SETTLE:  if (cnt_q == '0) state_d = S_CAPTURE;
                S_CAPTURE: state_d = S_EMIT;
                S_EMIT:    if (res_ready) state_d = (vec_q == '1) ? S_DONE : S_APPLY;
                S_DONE:    state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        vec_d       = vec_q;
        dut_n_d     = dut_n_q;
        res_vec_d   = res_vec_q;
        res_out_d   = res_out_q;
        res_valid_d = res_valid_q;
        cnt_d       = cnt_q;
        if (run_abort) begin
            dut_n_d     = '0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (go) vec_d = '0;
                S_APPLY: begin
                    dut_n_d = vec_q;
                    cnt_d   = SETTLE_LD;
                end
                S_SETTLE: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                S_CAPTURE: begin
                    res_out_d   = dut_out;
                    res_vec_d   = vec_q;
                    res_valid_d = 1'b1;
                end
                S_EMIT: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        if (vec_q != '1) vec_d = vec_q + N_W'(1);
                    end
                end
                S_DONE:  dut_n_d = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            vec_q       <= '0;
            dut_n_q     <= '0;
            res_vec_q   <= '0;
            res_out_q   <= '0;
            res_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            vec_q       <= vec_d;
            dut_n_q     <= dut_n_d;
            res_vec_q   <= res_vec_d;
            res_out_q   <= res_out_d;
            res_valid_q <= res_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        dut_n     = dut_n_q;
        res_vec   = res_vec_q;
        res_out   = res_out_q;
        res_valid = res_valid_q;
    end

`ifdef VSC_MISR_EN
    logic [SIG_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (run_abort || go) begin
            sig_d = '0;
        end else if (state_q == S_CAPTURE) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'({vec_q, dut_out});
        end
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_vec_sweep_ctrl.sv
// Bench for vec_sweep_ctrl: two instances (SETTLE=1 and SETTLE=0) driven with randomized
// backpressure and checked against a beat-order / parity / timing / signature model.
module tb_vec_sweep_ctrl;
    localparam int N_W   = 3;
    localparam int OUT_W = 1;
    localparam int SIG_W = 16;
    localparam logic [SIG_W-1:0] POLY = 16'h8016;
    localparam int NV = 1 << N_W;

    logic CK = 1'b0;
    logic reset;
    logic start_s [2];
    logic abort_s [2];
    logic ready_s [2];
    logic busy_s  [2];
    logic done_s  [2];
    logic valid_s [2];
    logic [N_W-1:0]   dutn_s [2];
    logic [N_W-1:0]   rvec_s [2];
    logic [OUT_W-1:0] dout_s [2];
    logic [OUT_W-1:0] rout_s [2];
    logic [SIG_W-1:0] sig_s  [2];

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    assign dout_s[0] = ^dutn_s[0];
    assign dout_s[1] = ^dutn_s[1];

    vec_sweep_ctrl #(.N_W(N_W), .OUT_W(OUT_W), .SETTLE(1), .SIG_W(SIG_W), .POLY(POLY)) u_dut_s1 (
        .CK(CK), .reset(reset), .start(start_s[0]), .abort(abort_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .dut_n(dutn_s[0]), .dut_out(dout_s[0]),
        .res_valid(valid_s[0]), .res_ready(ready_s[0]), .res_vec(rvec_s[0]),
        .res_out(rout_s[0]), .signature(sig_s[0])
    );

    vec_sweep_ctrl #(.N_W(N_W), .OUT_W(OUT_W), .SETTLE(0), .SIG_W(SIG_W), .POLY(POLY)) u_dut_s0 (
        .CK(CK), .reset(reset), .start(start_s[1]), .abort(abort_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .dut_n(dutn_s[1]), .dut_out(dout_s[1]),
        .res_valid(valid_s[1]), .res_ready(ready_s[1]), .res_vec(rvec_s[1]),
        .res_out(rout_s[1]), .signature(sig_s[1])
    );

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                    input logic [N_W-1:0] v,
                                                    input logic [OUT_W-1:0] o);
        logic [SIG_W-1:0] r;
        r = {s[SIG_W-2:0], 1'b0};
        if (s[SIG_W-1]) r = r ^ POLY;
        r = r ^ SIG_W'({v, o});
        return r;
    endfunction

    // d selects the instance (0: SETTLE=1, 1: SETTLE=0); mode 0 normal, 1 abort at vec 5,
    // 2 stray start at vec 2 then async reset at vec 6
    task automatic run_sweep(input int d, input int stall_pct, input int force_vec, input int mode);
        int next_vec;
        int stalls;
        int forced;
        int cyc;
        int per;
        bit prev_stall;
        bit finished;
        bit stray_done;
        bit seen_done;
        logic rdy;
        logic [N_W-1:0]   hv;
        logic [N_W-1:0]   hn;
        logic [N_W-1:0]   ev;
        logic [OUT_W-1:0] ho;
        logic [SIG_W-1:0] sig_m;
        next_vec = 0; stalls = 0; forced = 0; prev_stall = 0; finished = 0;
        stray_done = 0; seen_done = 0; sig_m = '0;
        hv = '0; hn = '0; ho = '0;
        per = ((d == 0) ? 1 : 0) + 3;
        start_s[d] = 1'b1;
        tick;
        start_s[d] = 1'b0;
        cyc = 1;
        checks++;
        if (busy_s[d] !== 1'b1)
            $display("FAIL busy_after_start inst=%0d got=%b exp=1", d, busy_s[d]);
        if (busy_s[d] !== 1'b1) errors++;
        while (!finished && cyc < 600) begin
            if (prev_stall) begin
                checks++;
                if (valid_s[d] !== 1'b1 || rvec_s[d] !== hv || rout_s[d] !== ho || dutn_s[d] !== hn) begin
                    errors++;
                    $display("FAIL stall_hold inst=%0d got v=%b vec=%0d out=%0d n=%0d exp v=1 vec=%0d out=%0d n=%0d",
                             d, valid_s[d], rvec_s[d], rout_s[d], dutn_s[d], hv, ho, hn);
                end
            end
            prev_stall = 0;
            if (mode == 1 && busy_s[d] && dutn_s[d] == N_W'(5)) begin
                abort_s[d] = 1'b1;
                ready_s[d] = 1'b1;
                tick;
                abort_s[d] = 1'b0;
                checks++;
                if (busy_s[d] !== 1'b0 || valid_s[d] !== 1'b0 || dutn_s[d] !== '0 || done_s[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_state inst=%0d got busy=%b valid=%b n=%0d done=%b exp all 0",
                             d, busy_s[d], valid_s[d], dutn_s[d], done_s[d]);
                end
                for (int i = 0; i < 20; i++) begin
                    tick;
                    if (done_s[d] !== 1'b0 || busy_s[d] !== 1'b0) seen_done = 1;
                end
                checks++;
                if (seen_done) begin
                    errors++;
                    $display("FAIL abort_quiet inst=%0d got done/busy activity after abort exp none", d);
                end
                checks++;
                if (sig_s[d] !== '0) begin
                    errors++;
                    $display("FAIL abort_sig inst=%0d got=%h exp=0", d, sig_s[d]);
                end
                finished = 1;
            end else if (mode == 2 && busy_s[d] && dutn_s[d] == N_W'(6)) begin
                reset = 1'b0;
                #1;
                checks++;
                if (busy_s[d] !== 1'b0 || done_s[d] !== 1'b0 || dutn_s[d] !== '0 || valid_s[d] !== 1'b0 ||
                    rvec_s[d] !== '0 || rout_s[d] !== '0 || sig_s[d] !== '0) begin
                    errors++;
                    $display("FAIL reset_async inst=%0d got busy=%b done=%b n=%0d valid=%b vec=%0d out=%0d sig=%h exp all 0",
                             d, busy_s[d], done_s[d], dutn_s[d], valid_s[d], rvec_s[d], rout_s[d], sig_s[d]);
                end
                tick;
                reset = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    tick;
                    if (done_s[d] !== 1'b0 || busy_s[d] !== 1'b0) seen_done = 1;
                end
                checks++;
                if (seen_done) begin
                    errors++;
                    $display("FAIL reset_idle inst=%0d got activity after reset release exp IDLE", d);
                end
                finished = 1;
            end else begin
                start_s[d] = 1'b0;
                if (mode == 2 && !stray_done && dutn_s[d] == N_W'(2)) begin
                    start_s[d] = 1'b1;
                    stray_done = 1;
                end
                if (valid_s[d]) begin
                    if (force_vec >= 0 && rvec_s[d] == N_W'(force_vec) && forced < 5) begin
                        rdy = 1'b0;
                        forced++;
                    end else begin
                        rdy = ($urandom_range(99) >= stall_pct);
                    end
                    ready_s[d] = rdy;
                    if (rdy) begin
                        ev = N_W'(next_vec);
                        checks++;
                        if (next_vec >= NV || rvec_s[d] !== ev || rout_s[d] !== OUT_W'(^ev)) begin
                            errors++;
                            $display("FAIL beat inst=%0d got vec=%0d out=%0d exp vec=%0d out=%0d",
                                     d, rvec_s[d], rout_s[d], next_vec, ^ev);
                        end
                        sig_m = misr_step(sig_m, ev, OUT_W'(^ev));
                        next_vec++;
                    end else begin
                        stalls++;
                        prev_stall = 1;
                        hv = rvec_s[d]; ho = rout_s[d]; hn = dutn_s[d];
                    end
                end else begin
                    ready_s[d] = 1'($urandom_range(1));
                end
                if (done_s[d]) begin
                    checks++;
                    if (cyc != NV * per + 1 + stalls || next_vec != NV) begin
                        errors++;
                        $display("FAIL done_timing inst=%0d got cycle=%0d beats=%0d exp cycle=%0d beats=%0d",
                                 d, cyc, next_vec, NV * per + 1 + stalls, NV);
                    end
`ifdef VSC_MISR_EN
                    checks++;
                    if (sig_s[d] !== sig_m) begin
                        errors++;
                        $display("FAIL signature inst=%0d got=%h exp=%h", d, sig_s[d], sig_m);
                    end
`else
                    checks++;
                    if (sig_s[d] !== '0) begin
                        errors++;
                        $display("FAIL signature_zero inst=%0d got=%h exp=0", d, sig_s[d]);
                    end
`endif
                    tick;
                    checks++;
                    if (done_s[d] !== 1'b0 || busy_s[d] !== 1'b0 || dutn_s[d] !== '0) begin
                        errors++;
                        $display("FAIL after_done inst=%0d got done=%b busy=%b n=%0d exp 0 0 0",
                                 d, done_s[d], busy_s[d], dutn_s[d]);
                    end
`ifdef VSC_MISR_EN
                    checks++;
                    if (sig_s[d] !== sig_m) begin
                        errors++;
                        $display("FAIL signature_hold inst=%0d got=%h exp=%h", d, sig_s[d], sig_m);
                    end
`endif
                    finished = 1;
                end else begin
                    tick;
                    cyc++;
                end
            end
        end
        start_s[d] = 1'b0;
        ready_s[d] = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL timeout inst=%0d got no done within %0d cycles exp done", d, cyc);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; abort_s[i] = 1'b0; ready_s[i] = 1'b0;
        end
        tick;
        tick;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy_s[i] !== 1'b0 || done_s[i] !== 1'b0 || dutn_s[i] !== '0 || valid_s[i] !== 1'b0 ||
                rvec_s[i] !== '0 || rout_s[i] !== '0 || sig_s[i] !== '0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d got busy=%b done=%b n=%0d valid=%b exp all 0",
                         i, busy_s[i], done_s[i], dutn_s[i], valid_s[i]);
            end
        end
        reset = 1'b1;
        tick;
        tick;
        checks++;
        if (busy_s[0] !== 1'b0 || busy_s[1] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b/%b exp 0/0", busy_s[0], busy_s[1]);
        end
    endtask

    task automatic test_basic;
        run_sweep(0, 0, -1, 0);
    endtask

    task automatic test_backpressure;
        run_sweep(0, 0, 3, 0);
    endtask

    task automatic test_abort;
        run_sweep(0, 0, -1, 1);
        run_sweep(0, 0, -1, 0);
    endtask

    task automatic test_start_ignored_reset;
        run_sweep(0, 0, -1, 2);
        run_sweep(0, 0, -1, 0);
    endtask

    task automatic test_settle0;
        run_sweep(1, 0, -1, 0);
    endtask

    task automatic test_idle_abort;
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        tick;
        start_s[0] = 1'b0;
        checks++;
        if (busy_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL start_with_abort got busy=%b exp 0", busy_s[0]);
        end
        tick;
        abort_s[0] = 1'b0;
        checks++;
        if (busy_s[0] !== 1'b0 || dutn_s[0] !== '0 || valid_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_abort got busy=%b n=%0d valid=%b exp 0 0 0", busy_s[0], dutn_s[0], valid_s[0]);
        end
        run_sweep(0, 0, -1, 0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 8; k++) begin
            run_sweep(int'($urandom_range(1)), int'($urandom_range(60)),
                      int'($urandom_range(8)) - 1, int'($urandom_range(2)));
            tick;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_start_ignored_reset();
        test_settle0();
        test_idle_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
